// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and parameters for the convolution sequencer
//
// Holds the sequencer state enum, default counter widths, the legal memory
// read latency range and the helper used by the elaboration-time range check.
package conv_pkg;

  localparam int CW_DEF     = 10;
  localparam int IW_DEF     = 16;
  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_HOLD  = 3'd4,
    ST_DONE  = 3'd5
  } conv_state_e;

  function automatic bit rd_lat_ok(input int lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/conv_dly_line.sv
// rtl/conv_dly_line.sv - fixed-depth shift register for latency-aligned strobes
//
// Delays a DW-bit vector by exactly DEPTH clock cycles.
// Ports:
//   clk, reset_n  clock, async active-low clear of every stage
//   d_i           vector entering the line
//   d_o           vector leaving the line DEPTH cycles later
module conv_dly_line #(
  parameter int DEPTH = 1,
  parameter int DW    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [DW-1:0] d_i,
  output logic [DW-1:0] d_o
);

  logic [DW-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) pipe_q[i] <= '0;
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign d_o = pipe_q[DEPTH-1];

endmodule

// File: rtl/conv_sched.sv
// rtl/conv_sched.sv - sequencer for the template-matching convolution datapath
//
// Drives the large-image address generator, issues MAC strobes aligned to the
// memory read latency and returns one result per window via valid/ready.
// Ports:
//   clk, reset_n             clock, async active-low reset
//   start                    job start, honoured only when idle
//   SI_Height_W, SI_Weight_W template size, sampled on accepted start
//   agen_done                conv_done from the address generator
//   res_ready                downstream accepts the window result
//   agen_reset, agen_enable  address generator control
//   count1                   template pixel index 0..H*W-1
//   mac_clr, mac_en          accumulator strobes, RD_LAT cycles behind RUN
//   res_valid, win_idx       window result handshake and window index
//   busy, done               job status
module conv_sched
  import conv_pkg::*;
#(
  parameter int RD_LAT = 1,
  parameter int CW     = CW_DEF,
  parameter int IW     = IW_DEF
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [8:0]    SI_Height_W,
  input  logic [8:0]    SI_Weight_W,
  input  logic          agen_done,
  input  logic          res_ready,
  output logic          agen_reset,
  output logic          agen_enable,
  output logic [CW-1:0] count1,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          res_valid,
  output logic [IW-1:0] win_idx,
  output logic          busy,
  output logic          done
);

  if (!rd_lat_ok(RD_LAT)) begin : g_rd_lat_bad
    $error("conv_sched: RD_LAT outside the supported range 1..4");
  end

  // Drain counter runs 0..RD_LAT-1; two bits cover the whole legal range.
  localparam logic [1:0] DRAIN_LAST = 2'(RD_LAT - 1);

  conv_state_e   state_q, state_d;
  logic [CW-1:0] count1_q, count1_d;
  logic [CW-1:0] limit_q, limit_d;
  logic [IW-1:0] win_idx_q, win_idx_d;
  logic          last_q, last_d;
  logic [1:0]    drain_q, drain_d;

  logic          accept;
  logic          run_end;
  logic [17:0]   hw_prod;
  logic [17:0]   hw_m1;
  logic [1:0]    dly_in;
  logic [1:0]    dly_out;

  assign accept  = start && (SI_Height_W != 9'd0) && (SI_Weight_W != 9'd0);
  assign run_end = (count1_q == limit_q);
  assign hw_prod = {9'd0, SI_Height_W} * {9'd0, SI_Weight_W};
  assign hw_m1   = hw_prod - 18'd1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count1_q  <= '0;
      limit_q   <= '0;
      win_idx_q <= '0;
      last_q    <= 1'b0;
      drain_q   <= '0;
    end else begin
      state_q   <= state_d;
      count1_q  <= count1_d;
      limit_q   <= limit_d;
      win_idx_q <= win_idx_d;
      last_q    <= last_d;
      drain_q   <= drain_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = ST_LOAD;
      ST_LOAD:  state_d = ST_RUN;
      ST_RUN:   if (run_end) state_d = ST_DRAIN;
      ST_DRAIN: if (drain_q == DRAIN_LAST) state_d = ST_HOLD;
      ST_HOLD:  if (res_ready) state_d = last_q ? ST_DONE : ST_RUN;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    count1_d  = count1_q;
    limit_d   = limit_q;
    win_idx_d = win_idx_q;
    last_d    = last_q;
    drain_d   = drain_q;
    case (state_q)
      ST_IDLE: if (accept) limit_d = CW'(hw_m1);
      ST_LOAD: begin
        count1_d  = '0;
        win_idx_d = '0;
        last_d    = 1'b0;
      end
      ST_RUN: begin
        // Wrapping here leaves count1 at 0 for the next window's RUN entry.
        count1_d = run_end ? '0 : count1_q + CW'(1);
        drain_d  = '0;
      end
      ST_DRAIN: begin
        // The generator registers conv_done on the final RUN edge, so it is
        // visible in the first drain cycle.
        if (drain_q == 2'd0) last_d = agen_done;
        drain_d = drain_q + 2'd1;
      end
      ST_HOLD: if (res_ready && !last_q) win_idx_d = win_idx_q + IW'(1);
      default: ;
    endcase
  end

  always_comb begin
    agen_reset  = 1'b0;
    agen_enable = 1'b0;
    res_valid   = 1'b0;
    done        = 1'b0;
    busy        = 1'b1;
    case (state_q)
      ST_IDLE: busy        = 1'b0;
      ST_LOAD: agen_reset  = 1'b1;
      ST_RUN:  agen_enable = 1'b1;
      ST_HOLD: res_valid   = 1'b1;
      ST_DONE: done        = 1'b1;
      default: ;
    endcase
  end

  assign count1  = count1_q;
  assign win_idx = win_idx_q;

  // The clear strobe marks the first pixel of a window so that, after the
  // read latency, it lands on that window's first accumulate.
  assign dly_in = {state_q == ST_RUN, (state_q == ST_RUN) && (count1_q == '0)};

  conv_dly_line #(
    .DEPTH (RD_LAT),
    .DW    (2)
  ) u_dly (
    .clk     (clk),
    .reset_n (reset_n),
    .d_i     (dly_in),
    .d_o     (dly_out)
  );

  assign mac_en  = dly_out[1];
  assign mac_clr = dly_out[0];

endmodule

// File: tb/tb_conv_sched.sv
// tb/tb_conv_sched.sv - randomized self-checking bench for conv_sched
module tb_conv_sched;

  localparam int CW   = 10;
  localparam int IW   = 16;
  localparam int NI   = 2;
  localparam int LAT0 = 1;
  localparam int LAT1 = 3;
  localparam int OW   = 7 + CW + IW;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [8:0] h_in, w_in;
  logic       res_ready;

  logic          ad [NI];
  logic          ar [NI];
  logic          ae [NI];
  logic [CW-1:0] c1 [NI];
  logic          mc [NI];
  logic          me [NI];
  logic          rv [NI];
  logic [IW-1:0] wi [NI];
  logic          bz [NI];
  logic          dn [NI];

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int t0;
  int cfg_nwin;

  // Job model per instance: cycle offsets from accept / window start.
  bit m_act [NI];
  int m_t0 [NI], m_n [NI], m_nwin [NI], m_ws [NI], m_w [NI], m_dcyc [NI], m_widx [NI];
  int gen_cnt [NI];

  int first_rv [NI], first_me [NI], first_mc [NI], done_rel [NI];
  int men_tot [NI], ae_tot [NI], rv_tot [NI], rst_cnt [NI], hs_n [NI];
  int hs_idx [NI][8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_sched #(.RD_LAT(LAT0), .CW(CW), .IW(IW)) u_dut0 (
    .clk(clk), .reset_n(reset_n), .start(start), .SI_Height_W(h_in), .SI_Weight_W(w_in),
    .agen_done(ad[0]), .res_ready(res_ready), .agen_reset(ar[0]), .agen_enable(ae[0]),
    .count1(c1[0]), .mac_clr(mc[0]), .mac_en(me[0]), .res_valid(rv[0]), .win_idx(wi[0]),
    .busy(bz[0]), .done(dn[0]));

  conv_sched #(.RD_LAT(LAT1), .CW(CW), .IW(IW)) u_dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .SI_Height_W(h_in), .SI_Weight_W(w_in),
    .agen_done(ad[1]), .res_ready(res_ready), .agen_reset(ar[1]), .agen_enable(ae[1]),
    .count1(c1[1]), .mac_clr(mc[1]), .mac_en(me[1]), .res_valid(rv[1]), .win_idx(wi[1]),
    .busy(bz[1]), .done(dn[1]));

  function automatic int lat_of(input int k);
    return (k == 0) ? LAT0 : LAT1;
  endfunction

  // Address generator stand-in: raises conv_done after nwin*N enables.
  always @(posedge clk or negedge reset_n) begin
    for (int k = 0; k < NI; k++) begin
      if (!reset_n || ar[k]) begin
        gen_cnt[k] <= 0;
        ad[k]      <= 1'b0;
      end else if (ae[k]) begin
        gen_cnt[k] <= gen_cnt[k] + 1;
        if (gen_cnt[k] + 1 == m_nwin[k] * m_n[k]) ad[k] <= 1'b1;
      end
    end
  end

  always @(posedge clk or negedge reset_n) begin : p_model
    int c;
    c = cyc;
    for (int k = 0; k < NI; k++) begin
      if (!reset_n) begin
        m_act[k]  <= 1'b0;
        m_widx[k] <= 0;
        m_dcyc[k] <= -1;
      end else if (!m_act[k]) begin
        if (start && h_in != 9'd0 && w_in != 9'd0) begin
          m_act[k]  <= 1'b1;
          m_t0[k]   <= c;
          m_ws[k]   <= c + 2;
          m_w[k]    <= 0;
          m_n[k]    <= int'(h_in) * int'(w_in);
          m_nwin[k] <= cfg_nwin;
          m_dcyc[k] <= -1;
        end
      end else if (c == m_t0[k] + 1) begin
        m_widx[k] <= 0;
      end else if (m_dcyc[k] >= 0) begin
        if (c == m_dcyc[k]) m_act[k] <= 1'b0;
      end else if ((c - m_ws[k] >= m_n[k] + lat_of(k)) && res_ready) begin
        if (m_w[k] == m_nwin[k] - 1) m_dcyc[k] <= c + 1;
        else begin
          m_ws[k]   <= c + 1;
          m_w[k]    <= m_w[k] + 1;
          m_widx[k] <= m_widx[k] + 1;
        end
      end
    end
  end

  function automatic logic [OW-1:0] model_out(input int k, input int c);
    bit b, d, r, e, cl, en, v;
    int cnt, o, n, l;
    {b, d, r, e, cl, en, v} = '0;
    cnt = 0;
    if (m_act[k]) begin
      b = 1'b1;
      if (c == m_t0[k] + 1) r = 1'b1;
      else if (m_dcyc[k] >= 0) d = (c == m_dcyc[k]);
      else begin
        o = c - m_ws[k];
        n = m_n[k];
        l = lat_of(k);
        if (o < n) begin
          e   = 1'b1;
          cnt = o;
        end else if (o >= n + l) v = 1'b1;
        en = (o >= l) && (o <= n - 1 + l);
        cl = (o == l);
      end
    end
    return {b, d, r, e, cl, en, v, CW'(cnt), IW'(m_widx[k])};
  endfunction

  function automatic logic [OW-1:0] dut_out(input int k);
    return {bz[k], dn[k], ar[k], ae[k], mc[k], me[k], rv[k], c1[k], wi[k]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_rec();
    for (int k = 0; k < NI; k++) begin
      first_rv[k] = -1; first_me[k] = -1; first_mc[k] = -1; done_rel[k] = -1;
      men_tot[k] = 0; ae_tot[k] = 0; rv_tot[k] = 0; rst_cnt[k] = 0; hs_n[k] = 0;
      for (int j = 0; j < 8; j++) hs_idx[k][j] = -1;
    end
  endtask

  task automatic compare_cycle();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("dut%0d_cyc%0d", k, cyc), 64'(dut_out(k)), 64'(model_out(k, cyc)));
      if (me[k]) begin men_tot[k]++; if (first_me[k] < 0) first_me[k] = cyc - t0; end
      if (mc[k] && first_mc[k] < 0) first_mc[k] = cyc - t0;
      if (ae[k]) ae_tot[k]++;
      if (ar[k]) rst_cnt[k]++;
      if (dn[k] && done_rel[k] < 0) done_rel[k] = cyc - t0;
      if (rv[k]) begin
        rv_tot[k]++;
        if (first_rv[k] < 0) first_rv[k] = cyc - t0;
        if (res_ready) begin
          if (hs_n[k] < 8) hs_idx[k][hs_n[k]] = int'(wi[k]);
          hs_n[k]++;
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_act[0] || m_act[1]) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) begin
      n_tests++;
      n_fail++;
      $display("FAIL idle_wait: still busy after %0d cycles, required idle", n);
    end
  endtask

  task automatic launch(input int h, input int w, input int nwin);
    wait_idle();
    cfg_nwin = nwin;
    h_in = 9'(h);
    w_in = 9'(w);
    clear_rec();
    start = 1'b1;
    t0 = cyc;
    tick();
    start = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; h_in = '0; w_in = '0; res_ready = 1'b1;
    cfg_nwin = 1; t0 = 0;
    clear_rec();
    fork
      forever begin
        @(negedge clk);
        compare_cycle();
      end
    join_none

    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) check($sformatf("reset_out%0d", k), 64'(dut_out(k)), 64'd0);
    reset_n = 1'b1;
    tick();

    // Three 2x2 windows with stray starts in RUN and HOLD.
    launch(2, 2, 3);
    repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    start = 1'b1; tick(); start = 1'b0;
    wait_idle();
    check("A_done_rel0", 64'(done_rel[0]), 64'd20);
    check("A_done_rel1", 64'(done_rel[1]), 64'd26);
    check("A_hs_n0", 64'(hs_n[0]), 64'd3);
    check("A_hs_idx0", 64'(hs_idx[0][0]), 64'd0);
    check("A_hs_idx1", 64'(hs_idx[0][1]), 64'd1);
    check("A_hs_idx2", 64'(hs_idx[0][2]), 64'd2);
    check("A_rst_cnt0", 64'(rst_cnt[0]), 64'd1);

    // Start with zero height is ignored.
    h_in = 9'd0; w_in = 9'd2;
    start = 1'b1; tick(); start = 1'b0;
    tick();
    check("Z_busy0", 64'(bz[0]), 64'd0);
    check("Z_busy1", 64'(bz[1]), 64'd0);

    // 3x2 template, single window.
    launch(3, 2, 1);
    wait_idle();
    check("B_first_me1", 64'(first_me[1]), 64'd5);
    check("B_first_mc1", 64'(first_mc[1]), 64'd5);
    check("B_men_tot1", 64'(men_tot[1]), 64'd6);
    check("B_first_rv1", 64'(first_rv[1]), 64'd11);
    check("B_first_me0", 64'(first_me[0]), 64'd3);
    check("B_first_rv0", 64'(first_rv[0]), 64'd9);

    // Result stalled in window 0.
    res_ready = 1'b0;
    launch(2, 2, 2);
    repeat (13) tick();
    res_ready = 1'b1;
    wait_idle();
    check("C_done_rel0", 64'(done_rel[0]), 64'd21);
    check("C_done_rel1", 64'(done_rel[1]), 64'd23);
    check("C_rv_tot0", 64'(rv_tot[0]), 64'd9);
    check("C_ae_tot0", 64'(ae_tot[0]), 64'd8);

    // Reset mid-RUN, then a fresh job.
    launch(2, 2, 3);
    repeat (3) tick();
    check("D_count1_0", 64'(c1[0]), 64'd2);
    check("D_count1_1", 64'(c1[1]), 64'd2);
    reset_n = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) check($sformatf("D_rst_out%0d", k), 64'(dut_out(k)), 64'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    launch(2, 2, 1);
    wait_idle();
    for (int k = 0; k < NI; k++) begin
      check($sformatf("E_rst_cnt%0d", k), 64'(rst_cnt[k]), 64'd1);
      check($sformatf("E_hs_idx%0d", k), 64'(hs_idx[k][0]), 64'd0);
    end
    check("E_done_rel0", 64'(done_rel[0]), 64'd8);
    check("E_done_rel1", 64'(done_rel[1]), 64'd10);

    // Full-range template: count1 wraps 1023 -> 0.
    launch(32, 32, 1);
    wait_idle();
    check("F_first_rv0", 64'(first_rv[0]), 64'd1027);
    check("F_first_rv1", 64'(first_rv[1]), 64'd1029);
    check("F_men_tot0", 64'(men_tot[0]), 64'd1024);
    check("F_men_tot1", 64'(men_tot[1]), 64'd1024);

    // Randomized jobs with random back-pressure and stray starts.
    for (int j = 0; j < 25; j++) begin
      launch($urandom_range(1, 6), $urandom_range(1, 6), $urandom_range(1, 4));
      for (int i = 0; i < 600 && (m_act[0] || m_act[1]); i++) begin
        res_ready = ($urandom_range(0, 3) != 0);
        start = ($urandom_range(0, 7) == 0);
        h_in = 9'($urandom_range(0, 6));
        w_in = 9'($urandom_range(1, 6));
        tick();
      end
      start = 1'b0;
      res_ready = 1'b1;
    end
    wait_idle();
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_sched.md
# conv_sched

Sequencer for the template-matching convolution datapath. It takes a `start` command and drives the large-image address generator with its `reset`, `enable` and `count1` inputs. It also issues MAC clear/accumulate strobes aligned to memory read latency and returns one result per window position through a valid/ready handshake. It sits between the top-level command logic and the address generator / MAC / result buffer.

## Interface
Parameters:
- `RD_LAT`, default 1: large-image memory read latency in cycles; legal range 1..4.
- `CW`, default 10: width of the template pixel counter `count1`.
- `IW`, default 16: width of the window index.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: start pulse; honoured only in IDLE.
- `SI_Height_W` in 9: template height; sampled on accepted `start`.
- `SI_Weight_W` in 9: template width; sampled on accepted `start`.
- `agen_done` in 1: `conv_done` from the address generator.
- `res_ready` in 1: downstream accepts the result.
- `agen_reset` out 1: active-high synchronous reset to the address generator.
- `agen_enable` out 1: enable to the address generator.
- `count1` out CW: template pixel index, 0..H*W-1.
- `mac_clr` out 1: clear the accumulator (first pixel of a window, latency-aligned).
- `mac_en` out 1: accumulate (latency-aligned).
- `res_valid` out 1: window result available.
- `win_idx` out IW: index of the current window.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse at end of job.

## Operation
- All outputs are 0 on reset.
- States: IDLE, LOAD, RUN, DRAIN, HOLD, DONE.
- IDLE:
  - `start`=1 with H≠0 and W≠0 → LOAD.
  - Latch `limit = H*W-1`, truncated to CW bits; H*W ≤ 2^CW is a caller obligation.
  - `start` with H=0 or W=0 is ignored; state stays IDLE.
- LOAD (1 cycle): `agen_reset`=1; `count1`←0, `win_idx`←0, `last`←0 → RUN.
- RUN:
  - `agen_enable`=1.
  - Each cycle `count1` increments; at `count1==limit` it wraps to 0 and the FSM goes to DRAIN.
- DRAIN (RD_LAT cycles):
  - `agen_enable`=0.
  - In the first DRAIN cycle, `last`←`agen_done`. The generator registers `conv_done` on the edge where `count1==limit`.
  - After the RD_LAT-th cycle → HOLD.
- HOLD:
  - `res_valid`=1 until the cycle where `res_ready`=1.
  - On handshake: if `last`, go to DONE; otherwise `win_idx`++ and go to RUN.
  - `count1` is already 0 on the RUN re-entry, and `agen_reset` is not reasserted.
- DONE (1 cycle): `done`=1 → IDLE.
- `mac_en` is `agen_enable` delayed by exactly RD_LAT cycles.
- `mac_clr` is (RUN ∧ `count1==0`) delayed by RD_LAT cycles, so it coincides with that window's first `mac_en`.
- `start` during `busy` is ignored, with no queuing.
- `reset_n` low mid-job returns the block to IDLE immediately, clears the delay line, and drops all outputs.
- `win_idx` wraps modulo 2^IW silently.

## Timing
- Accepted `start` at cycle 0:
  - LOAD at cycle 1.
  - RUN for cycles 2..N+1, where N=H*W.
  - `mac_en` high for cycles 2+RD_LAT..N+1+RD_LAT.
  - DRAIN for cycles N+2..N+1+RD_LAT.
  - `res_valid` first high at cycle N+2+RD_LAT.
- Window period with `res_ready` held high: N+RD_LAT+1 cycles.
- `res_valid` and `win_idx` are stable while HOLD stalls.
- `res_ready` outside HOLD has no effect.
- `done` asserts the cycle after the final handshake.
- `busy` falls the cycle after `done`.

## Structure
- Package `conv_pkg` holds:
  - the state enum;
  - `CW`/`IW` defaults;
  - RD_LAT bounds (1..4) and an elaboration check.
- Sub-module `conv_dly_line`: parameterised RD_LAT-deep shift register carrying {`mac_en`, `mac_clr`}, with async active-low clear.
- Top level holds the FSM, counters, and the `last` and limit registers.

## Test plan
- H=W=2, RD_LAT=1, `res_ready`=1, bench `agen_done` raised at the end of window 2:
  - `count1` sequence 0,1,2,3 ×3;
  - 3 `res_valid` pulses with `win_idx` 0,1,2;
  - `done` at cycle 3·6+2=20.
- H=3, W=2, RD_LAT=3:
  - `mac_clr` coincides with the first `mac_en` at cycle 5;
  - 6 `mac_en` cycles, 5..10;
  - `res_valid` at cycle 11.
- `res_ready` held low 7 cycles in window 0:
  - `res_valid` and `win_idx`=0 are held;
  - `agen_enable`=0 throughout;
  - RUN resumes the cycle after `res_ready`=1.
- `start` pulses in RUN and HOLD, and `start` with H=0 in IDLE: no state change, `busy` stays at its current value.
- `reset_n` low for 1 cycle mid-RUN with `count1`=2:
  - all outputs 0 asynchronously;
  - a later `start` reruns from `win_idx`=0 with one `agen_reset` pulse.
- H=W=32, CW=10: `limit`=1023, `count1` wraps 1023→0, `res_valid` at cycle 1026+RD_LAT.
